// File: rtl/mem_pkg.sv
// Shared types and constants for the parametrised scratch memory.
package mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/mem_array.sv
// Raw DEPTH x DATA_W register storage: one clocked write port, one read port
// whose data is captured into the output register by the parent.
module mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_param.sv
// Single-port synchronous RAM with post-reset clear sequencer, registered read
// data, read-valid pulse and ready flag. RW: 0 = write, 1 = read.
module mem_param
  import mem_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 3,
  parameter int DEPTH          = 2**ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              RW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] i,
  output logic [DATA_W-1:0] o,
  output logic              o_valid,
  output logic              ready
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [ADDR_W-1:0] clr_ptr_d;
  logic [DATA_W-1:0] o_q;
  logic              o_valid_q;
  logic              ready_q;

  logic              in_range;
  logic              acc_en;
  logic              user_wr;
  logic              user_rd;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  // Addresses past DEPTH exist only when DEPTH < 2**ADDR_W; they never reach the array.
  assign in_range  = ({1'b0, addr} < DEPTH_C);
  assign acc_en    = (state_q == IDLE) && ready_q && req;
  assign user_wr   = acc_en && (RW == RW_WRITE) && in_range;
  assign user_rd   = acc_en && (RW == RW_READ);
  assign clr_ptr_d = clr_ptr_q + 1'b1;

  // Reset itself must leave the contents alone, so rst blocks the clear write too.
  assign arr_we    = !rst && ((state_q == CLEAR) || user_wr);
  assign arr_waddr = (state_q == CLEAR) ? clr_ptr_q : addr;
  assign arr_wdata = (state_q == CLEAR) ? '0 : i;

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .raddr_i (addr),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_ptr_q <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      o_valid_q <= 1'b0;
      case (state_q)
        CLEAR: begin
          if (clr_ptr_q == LAST_C) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            clr_ptr_q <= clr_ptr_d;
          end
        end
        IDLE: begin
          ready_q <= 1'b1;
          if (user_rd) begin
            o_q       <= in_range ? arr_rdata : '0;
            o_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_mem_param.sv
// Directed bench for mem_param: default 8x8 instance plus a 12x16 instance.
module tb_mem_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        rw;
  logic [2:0]  addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dvld;
  logic        rdy;

  logic        rst2;
  logic        req2;
  logic        rw2;
  logic [3:0]  addr2;
  logic [15:0] din2;
  logic [15:0] dout2;
  logic        dvld2;
  logic        rdy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_param u_dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .RW      (rw),
    .addr    (addr),
    .i       (din),
    .o       (dout),
    .o_valid (dvld),
    .ready   (rdy)
  );

  mem_param #(
    .DATA_W (16),
    .ADDR_W (4),
    .DEPTH  (12)
  ) u_dut2 (
    .clk     (clk),
    .rst     (rst2),
    .req     (req2),
    .RW      (rw2),
    .addr    (addr2),
    .i       (din2),
    .o       (dout2),
    .o_valid (dvld2),
    .ready   (rdy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; rw = 1'b1; addr = '0; din = '0;
    rst2 = 1'b1; req2 = 1'b0; rw2 = 1'b1; addr2 = '0; din2 = '0;

    // Reset for two cycles.
    tick();
    tick();
    check("rst_ready", 32'(rdy), 32'd0);
    check("rst_o", 32'(dout), 32'd0);
    check("rst_vld", 32'(dvld), 32'd0);

    // Clear: ready low for 7 edges, high after the 8th; write attempt ignored.
    rst = 1'b0;
    req = 1'b1; rw = 1'b0; addr = 3'd5; din = 8'hAA;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("clr_ready_%0d", k), 32'(rdy), (k == 8) ? 32'd1 : 32'd0);
      check($sformatf("clr_o_%0d", k), 32'(dout), 32'd0);
      check($sformatf("clr_vld_%0d", k), 32'(dvld), 32'd0);
    end

    // Post-clear reads, back to back.
    rw = 1'b1;
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      tick();
      check($sformatf("zero_o_%0d", a), 32'(dout), 32'd0);
      check($sformatf("zero_vld_%0d", a), 32'(dvld), 32'd1);
    end

    // Writes 12..19.
    rw = 1'b0;
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a); din = 8'(12 + a);
      tick();
      check($sformatf("wr_vld_%0d", a), 32'(dvld), 32'd0);
    end
    rw = 1'b1;
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      tick();
      check($sformatf("rd_o_%0d", a), 32'(dout), 32'(12 + a));
      check($sformatf("rd_vld_%0d", a), 32'(dvld), 32'd1);
    end

    // Idle cycle: o holds, valid drops.
    req = 1'b0;
    tick();
    check("idle_o", 32'(dout), 32'd19);
    check("idle_vld", 32'(dvld), 32'd0);

    // Write then immediate read of the same address.
    req = 1'b1; rw = 1'b0; addr = 3'd2; din = 8'h77;
    tick();
    check("raw_wr_o", 32'(dout), 32'd19);
    rw = 1'b1;
    tick();
    check("raw_rd_o", 32'(dout), 32'h77);
    check("raw_rd_vld", 32'(dvld), 32'd1);

    // Reset mid-operation.
    rw = 1'b0; addr = 3'd3; din = 8'h55;
    tick();
    req = 1'b0; rst = 1'b1;
    tick();
    check("mid_rst_o", 32'(dout), 32'd0);
    check("mid_rst_ready", 32'(rdy), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("mid_clr_ready_%0d", k), 32'(rdy), (k == 8) ? 32'd1 : 32'd0);
    end
    req = 1'b1; rw = 1'b1; addr = 3'd3;
    tick();
    check("mid_rd_o", 32'(dout), 32'd0);
    check("mid_rd_vld", 32'(dvld), 32'd1);
    addr = 3'd4;
    tick();
    check("mid_rd4_o", 32'(dout), 32'd0);
    req = 1'b0;

    // Generalised instance: 12 words of 16 bits.
    tick();
    rst2 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("g_ready_%0d", k), 32'(rdy2), (k == 12) ? 32'd1 : 32'd0);
    end
    req2 = 1'b1; rw2 = 1'b0; addr2 = 4'd11; din2 = 16'hBEEF;
    tick();
    addr2 = 4'd13; din2 = 16'h1234;
    tick();
    check("g_wr_vld", 32'(dvld2), 32'd0);
    rw2 = 1'b1; addr2 = 4'd11;
    tick();
    check("g_rd11_o", 32'(dout2), 32'hBEEF);
    check("g_rd11_vld", 32'(dvld2), 32'd1);
    addr2 = 4'd13;
    tick();
    check("g_rd13_o", 32'(dout2), 32'd0);
    check("g_rd13_vld", 32'(dvld2), 32'd1);
    addr2 = 4'd1;
    tick();
    check("g_rd1_o", 32'(dout2), 32'd0);
    req2 = 1'b0;
    tick();
    check("g_idle_vld", 32'(dvld2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
